quote_feed_decoder: RTL and testbench
=====================================

Name: quote_feed_decoder

Overview:
- Producer end of the trigger block's bid_price/ask_price interface.
- Receives a byte-serial market-data quote stream over a valid/ready handshake and decodes bid and ask update messages.
- Verifies the checksum of each message and holds the current top-of-book prices in registers that drive the trigger comparators directly.
- Flags crossed books, and counts malformed or timed-out messages.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of clock cycles allowed between accepted bytes inside a message before the message is aborted.
- ERR_CNT_WIDTH, 8: width of the saturating error counter.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming feed byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  decoder can accept a byte; a byte transfers when rx_valid and rx_ready are both high at a rising edge.
- bid_price  output  8  current best bid; connects to trigger.bid_price.
- ask_price  output  8  current best ask; connects to trigger.ask_price.
- quote_valid  output  1  one-cycle pulse: bid_price/ask_price were just updated.
- book_crossed  output  1  level; high while bid_price >= ask_price and both are nonzero.
- checksum_error  output  1  one-cycle pulse on a rejected message.
- err_count  output  ERR_CNT_WIDTH  saturating count of rejected or aborted messages.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs go to 0 (rx_ready goes to 0 while reset is low) and the FSM goes to IDLE.
  - The timeout counter and the running checksum clear.
  - After reset deasserts, rx_ready is 1 from the first clock edge.
- Message formats (checksum = XOR of all preceding bytes of the message):
  - Bid update: 0xB1, price, csum.
  - Ask update: 0xA1, price, csum.
  - Both: 0xC1, bid, ask, csum.
- FSM states: IDLE, P1, P2, CSUM.
  - IDLE: an accepted byte of 0xB1 or 0xA1 goes to P1 with P2 skipped. An accepted 0xC1 goes to P1 with P2 required. Any other byte is silently dropped; it does not count as an error and the FSM stays in IDLE.
  - P1: accept the first price byte, then go to P2 (0xC1) or CSUM (0xA1/0xB1).
  - P2: accept the ask byte, then go to CSUM.
  - CSUM: accept the checksum byte, then return to IDLE.
- Opcode, prices and the running XOR are held in shadow registers. Outputs stay unchanged until the checksum is verified.
- Commit on a matching checksum, at the same edge that accepts the checksum byte:
  - The relevant price register(s) load from the shadow registers.
  - The other price register is unchanged.
  - quote_valid is high for exactly the following cycle.
  - Latency: outputs are visible one cycle after the checksum byte's transfer edge.
- Mismatch: shadow contents are discarded, checksum_error pulses for one cycle, err_count increments, FSM returns to IDLE.
- rx_ready is 1 in every state. The decoder never backpressures, so back-to-back messages are accepted with no idle cycle, and an opcode may arrive in the cycle after a checksum.
- Timeout:
  - The counter is active in P1, P2 and CSUM and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES with no accepted byte, the message aborts: FSM goes to IDLE, err_count increments, checksum_error pulses, and prices are unchanged.
  - In IDLE the counter is held at 0.
- err_count saturates at all-ones; it never wraps.
- book_crossed is registered: it is computed from the post-commit price values and changes in the same cycle as the prices.
- A mid-message reset discards any partial message. Prices return to 0.
- rx_valid low in any state: the FSM holds, and the timeout advances only in non-IDLE states.

Test Plan:
- Reset, then send B1 64 D5 -> cycle after the checksum edge: bid_price=0x64, ask_price=0x00, quote_valid pulses once, book_crossed=0, err_count=0.
- Send C1 50 52 C3 back-to-back with rx_valid held high -> bid_price=0x50, ask_price=0x52, one quote_valid pulse; then A1 55 F4 -> ask_price=0x55 and bid_price stays 0x50.
- Send B1 64 00 (bad checksum) -> bid_price unchanged, checksum_error pulses once, err_count=1, no quote_valid; a following valid message decodes correctly.
- Send C1 60 58 F9 -> bid_price=0x60, ask_price=0x58, book_crossed=1; then A1 70 D1 -> book_crossed=0.
- Send B1, then hold rx_valid low for 16 cycles -> abort with err_count +1 and checksum_error pulse; bytes 64 D5 that follow are dropped in IDLE (not opcodes) and the prices are unchanged.
- Send C1 50, then assert reset mid-message -> all outputs 0; after release, B1 22 93 -> bid_price=0x22. Drive 300 bad messages -> err_count saturates at 0xFF.

Source files
------------

// File: rtl/quote_feed_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quote_feed_decoder
// Description : Byte-serial quote feed decoder; checksums bid/ask updates and
//               holds top-of-book prices for the trigger comparators.
// Revision    : 1.0 - initial release
// ============================================================================
module quote_feed_decoder #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [7:0]               bid_price,
    output logic [7:0]               ask_price,
    output logic                     quote_valid,
    output logic                     book_crossed,
    output logic                     checksum_error,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam logic [7:0] c_OP_BID  = 8'hB1;
    localparam logic [7:0] c_OP_ASK  = 8'hA1;
    localparam logic [7:0] c_OP_BOTH = 8'hC1;

    localparam int                c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nx;
    logic                     r_ready;
    logic [7:0]               r_op;
    logic [7:0]               r_p1;
    logic [7:0]               r_p2;
    logic [7:0]               r_csum;
    logic [c_TMO_W-1:0]       r_tmo;
    logic [7:0]               r_bid;
    logic [7:0]               r_ask;
    logic                     r_qv;
    logic                     r_crossed;
    logic                     r_cerr;
    logic [ERR_CNT_WIDTH-1:0] r_err;

    logic       w_accept;
    logic       w_is_op;
    logic       w_tmo_hit;
    logic       w_commit;
    logic       w_reject;
    logic [7:0] w_bid_nx;
    logic [7:0] w_ask_nx;
    logic       w_crossed_nx;

    assign w_accept  = rx_valid & r_ready;
    assign w_is_op   = (rx_data == c_OP_BID) || (rx_data == c_OP_ASK) ||
                       (rx_data == c_OP_BOTH);
    // An accepted byte always wins over an expiring timeout on the same edge.
    assign w_tmo_hit = (r_state != S_IDLE) && !w_accept && (r_tmo == c_TMO_LAST);

    always_comb begin
        w_state_nx   = r_state;
        w_commit     = 1'b0;
        w_reject     = w_tmo_hit;
        w_bid_nx     = r_bid;
        w_ask_nx     = r_ask;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_op) w_state_nx = S_P1;
            end
            S_P1: begin
                if (w_accept)       w_state_nx = (r_op == c_OP_BOTH) ? S_P2 : S_CSUM;
                else if (w_tmo_hit) w_state_nx = S_IDLE;
            end
            S_P2: begin
                if (w_accept)       w_state_nx = S_CSUM;
                else if (w_tmo_hit) w_state_nx = S_IDLE;
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nx = S_IDLE;
                    if (rx_data == r_csum) w_commit = 1'b1;
                    else                   w_reject = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_commit) begin
            if (r_op != c_OP_ASK)  w_bid_nx = r_p1;
            if (r_op == c_OP_ASK)  w_ask_nx = r_p1;
            if (r_op == c_OP_BOTH) w_ask_nx = r_p2;
        end
        w_crossed_nx = (w_bid_nx >= w_ask_nx) && (w_bid_nx != 8'd0) && (w_ask_nx != 8'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ready <= 1'b1;
        end
    end

    // Shadow registers and timeout counter for the message in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op   <= 8'd0;
            r_p1   <= 8'd0;
            r_p2   <= 8'd0;
            r_csum <= 8'd0;
            r_tmo  <= '0;
        end else begin
            if (r_state == S_IDLE || w_accept || w_tmo_hit) r_tmo <= '0;
            else                                            r_tmo <= r_tmo + c_TMO_W'(1);
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        r_op   <= rx_data;
                        r_csum <= rx_data;
                    end
                    S_P1: begin
                        r_p1   <= rx_data;
                        r_csum <= r_csum ^ rx_data;
                    end
                    S_P2: begin
                        r_p2   <= rx_data;
                        r_csum <= r_csum ^ rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bid     <= 8'd0;
            r_ask     <= 8'd0;
            r_qv      <= 1'b0;
            r_crossed <= 1'b0;
            r_cerr    <= 1'b0;
            r_err     <= '0;
        end else begin
            r_bid     <= w_bid_nx;
            r_ask     <= w_ask_nx;
            r_qv      <= w_commit;
            r_crossed <= w_crossed_nx;
            r_cerr    <= w_reject;
            if (w_reject && (r_err != {ERR_CNT_WIDTH{1'b1}}))
                r_err <= r_err + ERR_CNT_WIDTH'(1);
        end
    end

    assign rx_ready       = r_ready;
    assign bid_price      = r_bid;
    assign ask_price      = r_ask;
    assign quote_valid    = r_qv;
    assign book_crossed   = r_crossed;
    assign checksum_error = r_cerr;
    assign err_count      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quote_feed_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quote_feed_decoder
// Description : Self-checking bench for quote_feed_decoder against a
//               message-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quote_feed_decoder;

    localparam int TMO = 16;

    logic       clock;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] bid_price;
    logic [7:0] ask_price;
    logic       quote_valid;
    logic       book_crossed;
    logic       checksum_error;
    logic [7:0] err_count;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [7:0] m_msg[$];
    int         m_need;
    int         m_idle;
    logic [7:0] m_bid, m_ask, m_cnt;
    logic       m_qv, m_ce, m_ready;

    quote_feed_decoder #(.TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(8)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .bid_price      (bid_price),
        .ask_price      (ask_price),
        .quote_valid    (quote_valid),
        .book_crossed   (book_crossed),
        .checksum_error (checksum_error),
        .err_count      (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_msg.delete();
        m_need  = 0;
        m_idle  = 0;
        m_bid   = 8'd0;
        m_ask   = 8'd0;
        m_cnt   = 8'd0;
        m_qv    = 1'b0;
        m_ce    = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic model_error();
        m_ce = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        m_msg.delete();
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d);
        logic       acc;
        logic [7:0] x;
        acc  = v && m_ready;
        m_qv = 1'b0;
        m_ce = 1'b0;
        if (m_msg.size() != 0) begin
            if (acc) begin
                m_msg.push_back(d);
                m_idle = 0;
                if (m_msg.size() == m_need) begin
                    x = 8'd0;
                    for (int i = 0; i < m_need - 1; i++) x = x ^ m_msg[i];
                    if (x == m_msg[m_need-1]) begin
                        m_qv = 1'b1;
                        if (m_msg[0] == 8'hB1) m_bid = m_msg[1];
                        else if (m_msg[0] == 8'hA1) m_ask = m_msg[1];
                        else begin
                            m_bid = m_msg[1];
                            m_ask = m_msg[2];
                        end
                        m_msg.delete();
                    end else begin
                        model_error();
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) model_error();
            end
        end else if (acc && (d == 8'hB1 || d == 8'hA1 || d == 8'hC1)) begin
            m_msg.push_back(d);
            m_idle = 0;
            m_need = (d == 8'hC1) ? 4 : 3;
        end
        m_ready = 1'b1;
    endtask

    function automatic logic model_crossed();
        return (m_bid >= m_ask) && (m_bid != 8'd0) && (m_ask != 8'd0);
    endfunction

    task automatic check_all();
        check_val("rx_ready", rx_ready, m_ready);
        check_val("bid_price", bid_price, m_bid);
        check_val("ask_price", ask_price, m_ask);
        check_val("quote_valid", quote_valid, m_qv);
        check_val("checksum_error", checksum_error, m_ce);
        check_val("err_count", err_count, m_cnt);
        check_val("book_crossed", book_crossed, model_crossed());
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clock);
        model_edge(v, d);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] b0, b1, b2, b3, input int n);
        logic [7:0] b[4];
        b = '{b0, b1, b2, b3};
        for (int i = 0; i < n; i++) step(1'b1, b[i]);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] op, p1, p2, cs;
        int         kind;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        #3;
        check_all();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        step(1'b0, 8'h00);
        check_val("ready_after_reset", rx_ready, 1'b1);

        send(8'hB1, 8'h64, 8'hD5, 8'h00, 3);
        check_val("dir_bid_64", bid_price, 8'h64);
        check_val("dir_qv_pulse", quote_valid, 1'b1);
        step(1'b0, 8'h00);
        check_val("dir_qv_once", quote_valid, 1'b0);

        send(8'hC1, 8'h50, 8'h52, 8'hC3, 4);
        send(8'hA1, 8'h55, 8'hF4, 8'h00, 3);
        check_val("dir_ask_55", ask_price, 8'h55);
        check_val("dir_bid_50", bid_price, 8'h50);

        send(8'hB1, 8'h64, 8'h00, 8'h00, 3);
        check_val("dir_bad_cerr", checksum_error, 1'b1);
        check_val("dir_bad_cnt", err_count, 8'd1);
        check_val("dir_bad_bid", bid_price, 8'h50);

        send(8'hC1, 8'h60, 8'h58, 8'hF9, 4);
        check_val("dir_crossed", book_crossed, 1'b1);
        send(8'hA1, 8'h70, 8'hD1, 8'h00, 3);
        check_val("dir_uncrossed", book_crossed, 1'b0);

        step(1'b1, 8'hB1);
        repeat (TMO) step(1'b0, 8'h00);
        check_val("dir_tmo_cerr", checksum_error, 1'b1);
        check_val("dir_tmo_cnt", err_count, 8'd2);
        send(8'h64, 8'hD5, 8'h00, 8'h00, 2);
        check_val("dir_tmo_bid", bid_price, 8'h60);

        send(8'hC1, 8'h50, 8'h00, 8'h00, 2);
        do_reset();
        check_val("dir_rst_bid", bid_price, 8'h00);
        step(1'b0, 8'h00);
        send(8'hB1, 8'h22, 8'h93, 8'h00, 3);
        check_val("dir_bid_22", bid_price, 8'h22);

        // Random traffic: good, corrupted, junk and stalled messages
        for (int m = 0; m < 300; m++) begin
            kind = $urandom_range(0, 9);
            op   = (kind < 3) ? 8'hB1 : (kind < 6) ? 8'hA1 : 8'hC1;
            p1   = 8'($urandom);
            p2   = 8'($urandom);
            cs   = (op == 8'hC1) ? (op ^ p1 ^ p2) : (op ^ p1);
            if ($urandom_range(0, 4) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            if (kind == 9) begin
                step(1'b1, 8'($urandom));
            end else begin
                for (int i = 0; i < ((op == 8'hC1) ? 4 : 3); i++) begin
                    if ($urandom_range(0, 15) == 0) repeat ($urandom_range(14, 18)) step(1'b0, 8'($urandom));
                    else repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom));
                    step(1'b1, (i == 0) ? op : (i == 1) ? p1 : (op == 8'hC1 && i == 2) ? p2 : cs);
                end
            end
        end

        for (int m = 0; m < 300; m++) send(8'hB1, 8'h01, 8'h00, 8'h00, 3);
        check_val("sat_cnt", err_count, 8'hFF);
        send(8'hB1, 8'h01, 8'h00, 8'h00, 3);
        check_val("sat_hold", err_count, 8'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
